sign_resize_pipe: RTL and testbench
===================================

Name: sign_resize_pipe

Overview:
Parametrised, pipelined width converter for signed and unsigned sample data. Each beat is optionally right-shifted with rounding, then narrowed or extended to OW bits using either wrap or saturation. Overflow is flagged per beat and accumulated in a sticky flag and a counter. The block sits between datapath stages whose widths differ and moves data over a valid/ready stream.

Parameters:
IW, 8, input data width (>=2)
OW, 4, output data width (>=1)
SHIFT, 0, fixed arithmetic right shift applied before resize (0..IW-1)
CW, 8, overflow counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  input beat valid
in_ready  output  1  block accepts a beat this cycle
in_data  input  IW  input sample
in_signed  input  1  1: two's complement, 0: unsigned; captured with the beat
in_sat  input  1  1: saturate on overflow, 0: wrap; captured with the beat
in_round  input  1  1: round half up on shift, 0: truncate; captured with the beat
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_data  output  OW  resized sample
out_ovf  output  1  this beat overflowed OW range
ovf_sticky  output  1  set by any transferred overflow beat
ovf_cnt  output  CW  count of transferred overflow beats, saturating
clr  input  1  synchronous clear of ovf_sticky and ovf_cnt

Behaviour:
- Reset (async): s1_valid, s2_valid, out_valid, out_data, out_ovf, ovf_sticky, ovf_cnt all 0. Beats in flight are discarded.
- Pipeline:
  - Two register stages; latency is 2 cycles from accepted input to out_valid when out_ready is held 1.
  - Enables: s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en (combinational from out_ready).
  - Throughput is 1 beat per cycle.
  - No beat is lost or duplicated, and order is preserved.
  - out_data and out_ovf stay stable while out_valid=1 and out_ready=0.
- Stage 1 (shift/round):
  - Extend in_data to IW+1 bits: sign-extend if in_signed, else zero-extend.
  - If in_round and SHIFT>0, add 2^(SHIFT-1).
  - Shift right by SHIFT: arithmetic if signed, logical if unsigned.
  - Store the result as W1 = IW-SHIFT+1 bits, so the rounding carry is never lost.
- Stage 2 (resize), with OW range: signed [-2^(OW-1), 2^(OW-1)-1], unsigned [0, 2^OW-1].
  - In range: out_data = value resized with sign or zero extension/truncation; out_ovf=0.
  - Out of range, wrap: out_data = low OW bits; out_ovf=1.
  - Out of range, saturate: out_data = max if value > max, min if value < min; out_ovf=1.
  - When OW >= W1 the value is always in range.
- Statistics:
  - On a transfer (out_valid & out_ready) with out_ovf=1: ovf_sticky <= 1 and ovf_cnt increments.
  - ovf_cnt holds at 2^CW-1; it never wraps.
  - clr has priority over a same-cycle overflow transfer: both ovf_sticky and ovf_cnt go to 0.
  - clr does not affect data beats.
- Mode bits travel with their beat. Changing a mode bit between beats affects only later beats.

Test Plan:
- Defaults, in_signed=1, in_sat=0, out_ready=1; in_data 0x05, 0xF9, 0x7F on consecutive cycles -> 2 cycles later out_data 0x5, 0x9, 0xF with out_ovf 0, 0, 1; ovf_cnt=1, ovf_sticky=1.
- Defaults, in_signed=1, in_sat=1; in_data 0x7F, 0x80 -> out_data 0x7, 0x8, out_ovf=1 both. Then in_signed=0, in_data 0x7F, 0x0A -> 0xF (ovf=1), 0xA (ovf=0).
- SHIFT=2, OW=8, signed; in_data 0x0E with in_round=1 -> 0x04; with in_round=0 -> 0x03. Unsigned 0xFF with in_round=1 -> 0x40, ovf=0.
- Backpressure: out_ready=0 for 3 cycles while 4 beats are offered back to back -> exactly 2 accepted, in_ready=0 afterwards, out_data held stable; after out_ready=1 all 4 beats emerge in order with no gaps or duplicates.
- CW=3, signed wrap, 9 back-to-back 0x7F beats -> ovf_cnt=7 (saturated). Then assert clr in the same cycle as an overflow transfer -> ovf_cnt=0, ovf_sticky=0.
- Drop rst_n mid-stream with both stages valid -> out_valid, ovf_cnt, ovf_sticky go to 0 immediately. After release, the first new beat appears 2 cycles after acceptance.

Source files
------------

// File: rtl/sign_resize_pipe.sv
// Two-stage signed/unsigned width converter: stage 1 extends, rounds and shifts;
// stage 2 resizes to OW with wrap or saturation and flags overflow.
module sign_resize_pipe #(
   parameter int IW    = 8,
   parameter int OW    = 4,
   parameter int SHIFT = 0,
   parameter int CW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_data,
   input  logic          in_signed,
   input  logic          in_sat,
   input  logic          in_round,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          out_ovf,
   output logic          ovf_sticky,
   output logic [CW-1:0] ovf_cnt,
   input  logic          clr
);

   localparam int W1 = IW - SHIFT + 1;
   // Half an LSB of the shifted result; zero when SHIFT == 0.
   localparam logic [IW:0] HALF = ({{IW{1'b0}}, 1'b1} << SHIFT) >> 1;
   localparam logic [OW-1:0] SMAX = {OW{1'b1}} >> 1;
   localparam logic [OW-1:0] SMIN = ~SMAX;

   logic [2:1]    vld_pipe_q;
   logic          s1_en, s2_en;
   logic [IW:0]   ext, rnd;
   logic [W1-1:0] s1_val_d, s1_val_q;
   logic          s1_sgn_q, s1_sat_q;
   logic [OW-1:0] res_d;
   logic          ovf_d;
   logic          ovf_sticky_d;
   logic [CW-1:0] ovf_cnt_d;

   assign s2_en     = !vld_pipe_q[2] | out_ready;
   assign s1_en     = !vld_pipe_q[1] | s2_en;
   assign in_ready  = s1_en;
   assign out_valid = vld_pipe_q[2];

   // Extra top bit keeps the rounding carry; the kept slice is the same for
   // arithmetic and logical shifts since only the sign interpretation differs.
   always_comb begin
      ext      = {in_signed & in_data[IW-1], in_data};
      rnd      = ext + (in_round ? HALF : '0);
      s1_val_d = W1'(rnd >> SHIFT);
   end

   generate
      if (OW < W1) begin : g_narrow
         always_comb begin
            res_d = s1_val_q[OW-1:0];
            ovf_d = 1'b0;
            if (s1_sgn_q) begin
               if (!(&s1_val_q[W1-1:OW-1]) && (|s1_val_q[W1-1:OW-1])) begin
                  ovf_d = 1'b1;
                  if (s1_sat_q) res_d = s1_val_q[W1-1] ? SMIN : SMAX;
               end
            end else if (|s1_val_q[W1-1:OW]) begin
               ovf_d = 1'b1;
               if (s1_sat_q) res_d = '1;
            end
         end
      end else begin : g_wide
         always_comb begin
            res_d = s1_sgn_q ? OW'($signed(s1_val_q)) : OW'(s1_val_q);
            ovf_d = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         s1_val_q   <= '0;
         s1_sgn_q   <= 1'b0;
         s1_sat_q   <= 1'b0;
         out_data   <= '0;
         out_ovf    <= 1'b0;
      end else begin
         if (s1_en) begin
            vld_pipe_q[1] <= in_valid;
            s1_val_q      <= s1_val_d;
            s1_sgn_q      <= in_signed;
            s1_sat_q      <= in_sat;
         end
         if (s2_en) begin
            vld_pipe_q[2] <= vld_pipe_q[1];
            out_data      <= res_d;
            out_ovf       <= ovf_d;
         end
      end
   end

   // clr wins over a same-cycle overflow transfer; counter saturates.
   always_comb begin
      ovf_sticky_d = ovf_sticky;
      ovf_cnt_d    = ovf_cnt;
      if (clr) begin
         ovf_sticky_d = 1'b0;
         ovf_cnt_d    = '0;
      end else if (out_valid && out_ready && out_ovf) begin
         ovf_sticky_d = 1'b1;
         if (ovf_cnt != {CW{1'b1}}) ovf_cnt_d = ovf_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         ovf_cnt    <= '0;
      end else begin
         ovf_sticky <= ovf_sticky_d;
         ovf_cnt    <= ovf_cnt_d;
      end
   end

endmodule

// File: tb/tb_sign_resize_pipe.sv
// Directed bench: three instances (default, SHIFT=2/OW=8, CW=3) share stimulus;
// each vector names the instance whose output it checks.
module tb_sign_resize_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_signed = 1'b1, in_sat = 1'b0, in_round = 1'b0;
   logic       out_ready = 1'b1, clr = 1'b0;

   logic       rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2, st0, st1, st2;
   logic [3:0] od0, od2;
   logic [7:0] od1, cnt0, cnt1;
   logic [2:0] cnt2;

   always #5 clk = ~clk;

   sign_resize_pipe #(.IW(8), .OW(4), .SHIFT(0), .CW(8)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .in_signed(in_signed), .in_sat(in_sat), .in_round(in_round), .out_valid(ov0),
      .out_ready(out_ready), .out_data(od0), .out_ovf(of0), .ovf_sticky(st0),
      .ovf_cnt(cnt0), .clr(clr));
   sign_resize_pipe #(.IW(8), .OW(8), .SHIFT(2), .CW(8)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .in_signed(in_signed), .in_sat(in_sat), .in_round(in_round), .out_valid(ov1),
      .out_ready(out_ready), .out_data(od1), .out_ovf(of1), .ovf_sticky(st1),
      .ovf_cnt(cnt1), .clr(clr));
   sign_resize_pipe #(.IW(8), .OW(4), .SHIFT(0), .CW(3)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
      .in_signed(in_signed), .in_sat(in_sat), .in_round(in_round), .out_valid(ov2),
      .out_ready(out_ready), .out_data(od2), .out_ovf(of2), .ovf_sticky(st2),
      .ovf_cnt(cnt2), .clr(clr));

   typedef struct {
      logic [7:0] d;
      logic       sg, st, rd;
      int         dut;
      logic [7:0] ed;
      logic       eo;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {valid, ovf, data} of the selected instance
   function automatic logic [31:0] obs(input int d);
      case (d)
         0:       obs = {22'd0, ov0, of0, 4'd0, od0};
         1:       obs = {22'd0, ov1, of1, od1};
         default: obs = {22'd0, ov2, of2, 4'd0, od2};
      endcase
   endfunction

   // Beat i is driven before edge i+1 and shows at the output after edge i+2.
   task automatic run_vec(input string name);
      for (int i = 0; i <= vq.size(); i++) begin
         if (i < vq.size()) begin
            in_valid  = 1'b1;
            in_data   = vq[i].d;
            in_signed = vq[i].sg;
            in_sat    = vq[i].st;
            in_round  = vq[i].rd;
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (i >= 1)
            check($sformatf("%s_%0d", name, i - 1), obs(vq[i-1].dut),
                  {22'd0, 1'b1, vq[i-1].eo, vq[i-1].ed});
      end
      vq.delete();
   endtask

   initial begin
      int sent;

      #12;
      check("rst_valid", 32'(ov0), 32'(0));
      check("rst_data", 32'(od0), 32'(0));
      check("rst_ovf", 32'(of0), 32'(0));
      check("rst_sticky", 32'(st0), 32'(0));
      check("rst_cnt", 32'(cnt0), 32'(0));
      check("rst_ready", 32'(rdy0), 32'(1));
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // signed wrap
      vq.push_back('{8'h05, 1'b1, 1'b0, 1'b0, 0, 8'h05, 1'b0});
      vq.push_back('{8'hF9, 1'b1, 1'b0, 1'b0, 0, 8'h09, 1'b0});
      vq.push_back('{8'h7F, 1'b1, 1'b0, 1'b0, 0, 8'h0F, 1'b1});
      run_vec("wrap");
      step();
      check("wrap_cnt", 32'(cnt0), 32'(1));
      check("wrap_sticky", 32'(st0), 32'(1));

      // saturation, mode bits changing per beat
      vq.push_back('{8'h7F, 1'b1, 1'b1, 1'b0, 0, 8'h07, 1'b1});
      vq.push_back('{8'h80, 1'b1, 1'b1, 1'b0, 0, 8'h08, 1'b1});
      vq.push_back('{8'h7F, 1'b0, 1'b1, 1'b0, 0, 8'h0F, 1'b1});
      vq.push_back('{8'h0A, 1'b0, 1'b1, 1'b0, 0, 8'h0A, 1'b0});
      vq.push_back('{8'h13, 1'b0, 1'b0, 1'b0, 0, 8'h03, 1'b1});
      run_vec("sat");

      // SHIFT=2, OW=8 rounding
      vq.push_back('{8'h0E, 1'b1, 1'b0, 1'b1, 1, 8'h04, 1'b0});
      vq.push_back('{8'h0E, 1'b1, 1'b0, 1'b0, 1, 8'h03, 1'b0});
      vq.push_back('{8'hFF, 1'b0, 1'b0, 1'b1, 1, 8'h40, 1'b0});
      vq.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1, 8'h00, 1'b0});
      vq.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 1, 8'hFF, 1'b0});
      vq.push_back('{8'h80, 1'b0, 1'b0, 1'b0, 1, 8'h20, 1'b0});
      run_vec("shift");
      step();
      step();

      // backpressure: 3 stalled cycles, 4 beats offered
      sent = 0;
      out_ready = 1'b0;
      in_signed = 1'b0;
      in_sat = 1'b0;
      in_round = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(sent + 1);
         #1;
         if (c == 2) check("bp_hold_stall", obs(0), {22'd0, 1'b1, 1'b0, 8'h01});
         if (rdy0) sent++;
         step();
      end
      check("bp_accepted", 32'(sent), 32'(2));
      check("bp_ready_low", 32'(rdy0), 32'(0));
      for (int r = 0; r < 4; r++) begin
         out_ready = 1'b1;
         in_valid  = (sent < 4);
         in_data   = 8'(sent + 1);
         #1;
         check($sformatf("bp_out_%0d", r), obs(0), {22'd0, 1'b1, 1'b0, 8'(r + 1)});
         if (rdy0 && in_valid) sent++;
         step();
      end
      in_valid = 1'b0;
      check("bp_drained", 32'(ov0), 32'(0));
      check("bp_sent", 32'(sent), 32'(4));

      // CW=3 counter saturation, then clr against an overflow transfer
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("cw_clr", 32'(cnt2), 32'(0));
      for (int k = 0; k < 9; k++) vq.push_back('{8'h7F, 1'b1, 1'b0, 1'b0, 2, 8'h0F, 1'b1});
      run_vec("cw");
      step();
      check("cw_cnt_sat", 32'(cnt2), 32'(7));
      check("cw_sticky", 32'(st2), 32'(1));
      in_valid = 1'b1;
      in_data  = 8'h7F;
      step();
      in_valid = 1'b0;
      step();
      check("clr_beat", obs(2), {22'd0, 1'b1, 1'b1, 8'h0F});
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_cnt", 32'(cnt2), 32'(0));
      check("clr_sticky", 32'(st2), 32'(0));
      check("clr_beat_gone", 32'(ov2), 32'(0));

      // async reset with both stages full
      vq.push_back('{8'h7F, 1'b1, 1'b0, 1'b0, 0, 8'h0F, 1'b1});
      run_vec("pre");
      step();
      check("pre_sticky", 32'(st0), 32'(1));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h05;
      step();
      step();
      check("pre_full", 32'(ov0), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(ov0), 32'(0));
      check("ar_cnt", 32'(cnt0), 32'(0));
      check("ar_sticky", 32'(st0), 32'(0));
      check("ar_data", 32'(od0), 32'(0));
      #2 rst_n = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b1;
      in_signed = 1'b1;
      in_data   = 8'h03;
      step();
      in_valid = 1'b0;
      check("ar_lat1", 32'(ov0), 32'(0));
      step();
      check("ar_lat2", obs(0), {22'd0, 1'b1, 1'b0, 8'h03});
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
